spi_master: RTL and testbench
=============================

# spi_master

SPI master (mode 0: CPOL=0, CPHA=0, MSB first) that drives the host end of the byte link terminated by the on-chip `spi` slave. Bytes offered on an Avalon-ST sink are shifted out on `mosi`. Bytes shifted in on `miso` are presented on an Avalon-ST source. The block is the board-side/bench-side loader that pushes input, weight and bias bytes to the accelerator and reads back convolution results.

## Interface
Parameters:
- `CLK_DIV`, 4: clk cycles per sclk half-period; legal range is 2 or more.
- `CSS_CYCLES`, 2: clk cycles of nss setup before the first sclk edge, nss hold after the last edge, and minimum nss-high gap; legal range is 1 or more.

Ports:
- `clk` input 1: single system clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `stsinkdata` input 8: byte to transmit.
- `stsinkvalid` input 1: `stsinkdata` is valid.
- `stsinkready` output 1: the byte is accepted on a cycle where `stsinkvalid` && `stsinkready`.
- `stsourcedata` output 8: received byte.
- `stsourcevalid` output 1: `stsourcedata` is valid; held until consumed.
- `stsourceready` input 1: the byte is consumed on a cycle where `stsourcevalid` && `stsourceready`.
- `sclk` output 1: SPI clock, idle low.
- `mosi` output 1: serial data out.
- `miso` input 1: serial data in.
- `nss` output 1: slave select, active low.
- `busy` output 1: high in any state other than IDLE.

## Operation
- States: IDLE, SETUP, SHIFT_LOW, SHIFT_HIGH, NEXT, HOLD, GAP.
- Internal state: one phase counter (width for max(CLK_DIV, CSS_CYCLES)), a 3-bit bit counter, an 8-bit tx shift register, an 8-bit rx shift register, and a 1-deep rx output register.
- `stsinkready` = (state==IDLE || state==NEXT) && !stsourcevalid. It is combinational from registered state. No byte is started while a received byte is unconsumed, so rx overflow cannot occur.
- **IDLE:** nss=1, sclk=0, mosi=0. On sink accept: load the tx register, go to SETUP.
- **SETUP:** lasts CSS_CYCLES. nss=0, sclk=0, mosi=tx[7]. Then go to SHIFT_LOW.
- **SHIFT_LOW:** lasts CLK_DIV cycles. sclk=0, mosi=current bit. Then go to SHIFT_HIGH.
- **SHIFT_HIGH:** lasts CLK_DIV cycles. sclk=1.
  - `miso` is sampled into the rx register on the last cycle of SHIFT_HIGH, immediately before the falling edge.
  - On exit the tx register shifts left and the bit counter increments.
  - After bit 7 (the 8th bit), go to NEXT. Otherwise go to SHIFT_LOW.
- **Entry to NEXT:** the rx byte is copied to `stsourcedata` and `stsourcevalid` is set.
- **NEXT:** nss=0, sclk=0, mosi holds the last bit.
  - While `stsourcevalid` is high, wait; sclk stays low indefinitely.
  - Once `stsourcevalid` is clear: if `stsinkvalid`, accept the byte and go to SHIFT_LOW with no SETUP, so nss stays low across the byte boundary. Otherwise go to HOLD.
  - If the drain and the new accept would fall on the same cycle, the accept is deferred one cycle, because `stsinkready` is still low during the drain cycle.
- **HOLD:** lasts CSS_CYCLES. nss=0, sclk=0. Then go to GAP.
- **GAP:** lasts CSS_CYCLES. nss=1, sclk=0, mosi=0, `stsinkready`=0. Then go to IDLE.
- `stsourcevalid` clears on the consume handshake. A consume can occur in any state.
- **Reset**, including mid-transfer, on the next edge:
  - State goes to IDLE and counters clear.
  - nss=1, sclk=0, mosi=0.
  - `stsourcevalid`=0, `stsourcedata`=8'h00, busy=0.
  - `stsinkready` is 0 while reset is asserted.
  - A partial byte is discarded and never presented.

## Timing
- All SPI outputs are registered; there is no combinational path from `miso` to any output.
- Single byte, with the sink accept at cycle 0:
  - Cycle 1: nss falls.
  - Cycle 1+CSS_CYCLES: first sclk low phase begins.
  - Byte body: 16*CLK_DIV cycles.
  - Cycle 1+CSS_CYCLES+16*CLK_DIV: `stsourcevalid` rises.
- nss returns high 1+CSS_CYCLES cycles after the exit from NEXT.
- Back-to-back bytes, with the sink valid and the source drained: the next byte's first low phase starts 2 cycles after the last falling sclk edge (NEXT entry plus accept). This assumes `stsourceready` is tied high, so the drain happens on the first NEXT cycle.
- Minimum nss-high time between transactions is CSS_CYCLES+1 cycles (GAP plus IDLE).

## Test plan
- CLK_DIV=4, CSS_CYCLES=2; send 0xA5 with a bench slave returning 0x3C.
  - mosi on the 8 rising edges reads 1,0,1,0,0,1,0,1.
  - `stsourcedata`=0x3C.
  - Exactly 8 sclk pulses, each 4 cycles high and 4 low.
  - nss low for 2+64+1+2 cycles around them.
- Stream 0x3C, 0xC3, 0xFF with `stsourceready` tied high and mosi looped back to miso.
  - nss stays low across all 3 bytes.
  - Received sequence is 0x3C, 0xC3, 0xFF.
  - nss rises once at the end.
- Backpressure: hold `stsourceready` low for 50 cycles after byte 1 while byte 2 is valid.
  - sclk stays low and nss stays low.
  - `stsinkready`=0 throughout the stall.
  - Byte 2 starts 2 cycles after the drain.
- Reset asserted after the 3rd rising sclk edge.
  - Next edge: nss=1, sclk=0, busy=0.
  - `stsourcevalid` never rises for the aborted byte.
  - A new 0x81 afterwards transfers cleanly.
- Loopback with patterns 0x00 and 0xFF at CLK_DIV=2.
  - Received bytes equal transmitted bytes.
  - Two consecutive transactions are separated by at least 3 nss-high cycles.

Source files
------------

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master bridging Avalon-ST byte streams to a serial link
module spi_master #(
    parameter int CLK_DIV    = 4,
    parameter int CSS_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] stsinkdata,
    input  logic       stsinkvalid,
    output logic       stsinkready,
    output logic [7:0] stsourcedata,
    output logic       stsourcevalid,
    input  logic       stsourceready,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       nss,
    output logic       busy
);
    localparam int MAX_CNT = (CLK_DIV > CSS_CYCLES) ? CLK_DIV : CSS_CYCLES;
    localparam int PW      = $clog2(MAX_CNT + 1);
    localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] CSS_LAST = PW'(CSS_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, SHIFT_LOW, SHIFT_HIGH, NEXT, HOLD, GAP
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] phase;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_sr;
    // Only seven earlier bits are kept; the eighth comes straight from miso.
    logic [6:0]    rx_sr;
    logic [7:0]    rx_next;
    logic          sink_fire;
    logic          source_fire;
    logic          load_tx;
    logic          shift_bit;

    assign stsinkready = !reset && (state == IDLE || state == NEXT) && !stsourcevalid;
    assign busy        = (state != IDLE);

    always_comb begin
        state_next  = state;
        load_tx     = 1'b0;
        shift_bit   = 1'b0;
        sink_fire   = stsinkvalid && stsinkready;
        source_fire = stsourcevalid && stsourceready;
        rx_next     = {rx_sr, miso};
        case (state)
            IDLE: begin
                if (sink_fire) begin
                    load_tx    = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP:     if (phase == CSS_LAST) state_next = SHIFT_LOW;
            SHIFT_LOW: if (phase == DIV_LAST) state_next = SHIFT_HIGH;
            SHIFT_HIGH: begin
                if (phase == DIV_LAST) begin
                    shift_bit  = 1'b1;
                    state_next = (bit_cnt == 3'd7) ? NEXT : SHIFT_LOW;
                end
            end
            NEXT: begin
                // A pending byte waits out the drain cycle; with none pending we leave at once.
                if (sink_fire) begin
                    load_tx    = 1'b1;
                    state_next = SHIFT_LOW;
                end else if ((!stsourcevalid || source_fire) && !stsinkvalid) begin
                    state_next = HOLD;
                end
            end
            HOLD:    if (phase == CSS_LAST) state_next = GAP;
            GAP:     if (phase == CSS_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            phase         <= '0;
            bit_cnt       <= 3'd0;
            tx_sr         <= 8'h00;
            rx_sr         <= 7'h00;
            stsourcedata  <= 8'h00;
            stsourcevalid <= 1'b0;
            sclk          <= 1'b0;
            mosi          <= 1'b0;
            nss           <= 1'b1;
        end else begin
            state <= state_next;
            phase <= (state_next != state) ? '0 : phase + PW'(1);

            if (load_tx) begin
                tx_sr <= stsinkdata;
            end else if (shift_bit) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end

            if (shift_bit) begin
                rx_sr   <= rx_next[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (shift_bit && bit_cnt == 3'd7) begin
                stsourcedata  <= rx_next;
                stsourcevalid <= 1'b1;
            end else if (source_fire) begin
                stsourcevalid <= 1'b0;
            end

            // Pins are driven from the next state so they change together with it.
            nss  <= (state_next == IDLE || state_next == GAP);
            sclk <= (state_next == SHIFT_HIGH);
            case (state_next)
                IDLE, GAP: mosi <= 1'b0;
                SETUP, SHIFT_LOW, SHIFT_HIGH: begin
                    if (load_tx) begin
                        mosi <= stsinkdata[7];
                    end else if (shift_bit) begin
                        mosi <= tx_sr[6];
                    end else begin
                        mosi <= tx_sr[7];
                    end
                end
                default: mosi <= mosi;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - randomized self-checking bench for spi_master
module tb_spi_master;
    localparam int DIV  = 4;
    localparam int CSS  = 2;
    localparam int DIV2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] stsinkdata;
    logic       stsinkvalid, stsinkready;
    logic [7:0] stsourcedata;
    logic       stsourcevalid, stsourceready;
    logic       sclk, mosi, miso, nss, busy;

    logic       reset2;
    logic [7:0] stsinkdata2;
    logic       stsinkvalid2, stsinkready2;
    logic [7:0] stsourcedata2;
    logic       stsourcevalid2, stsourceready2;
    logic       sclk2, mosi2, miso2, nss2, busy2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    spi_master #(.CLK_DIV(DIV), .CSS_CYCLES(CSS)) dut (
        .clk(clk), .reset(reset),
        .stsinkdata(stsinkdata), .stsinkvalid(stsinkvalid), .stsinkready(stsinkready),
        .stsourcedata(stsourcedata), .stsourcevalid(stsourcevalid), .stsourceready(stsourceready),
        .sclk(sclk), .mosi(mosi), .miso(miso), .nss(nss), .busy(busy)
    );

    spi_master #(.CLK_DIV(DIV2), .CSS_CYCLES(CSS)) dut2 (
        .clk(clk), .reset(reset2),
        .stsinkdata(stsinkdata2), .stsinkvalid(stsinkvalid2), .stsinkready(stsinkready2),
        .stsourcedata(stsourcedata2), .stsourcevalid(stsourcevalid2), .stsourceready(stsourceready2),
        .sclk(sclk2), .mosi(mosi2), .miso(miso2), .nss(nss2), .busy(busy2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Bench slave: mode 0, returns slave_byte MSB first, advancing on falling sclk.
    logic       loopback;
    logic [7:0] slave_byte;
    logic [2:0] slave_idx = 3'd7;
    always @(negedge nss)  slave_idx <= 3'd7;
    always @(negedge sclk) slave_idx <= slave_idx - 3'd1;
    assign miso  = loopback ? mosi : slave_byte[slave_idx];
    assign miso2 = mosi2;

    int   rise_cyc[$], fall_cyc[$], nss_fall_cyc[$], nss_rise_cyc[$];
    int   acc_cyc[$], drain_cyc[$], vrise_cyc[$];
    logic rise_bit[$];
    logic [7:0] rx_q[$];
    logic prev_sclk = 1'b0, prev_nss = 1'b1, prev_valid = 1'b0;

    always @(negedge clk) begin
        if (sclk === 1'b1 && prev_sclk === 1'b0) begin
            rise_cyc.push_back(cyc);
            rise_bit.push_back(mosi);
        end
        if (sclk === 1'b0 && prev_sclk === 1'b1) fall_cyc.push_back(cyc);
        if (nss === 1'b0 && prev_nss === 1'b1) nss_fall_cyc.push_back(cyc);
        if (nss === 1'b1 && prev_nss === 1'b0) nss_rise_cyc.push_back(cyc);
        if (stsinkvalid === 1'b1 && stsinkready === 1'b1) acc_cyc.push_back(cyc);
        if (stsourcevalid === 1'b1 && stsourceready === 1'b1) begin
            drain_cyc.push_back(cyc);
            rx_q.push_back(stsourcedata);
        end
        if (stsourcevalid === 1'b1 && prev_valid !== 1'b1) vrise_cyc.push_back(cyc);
        prev_sclk  <= sclk;
        prev_nss   <= nss;
        prev_valid <= stsourcevalid;
    end

    int         nss2_fall_cyc[$], nss2_rise_cyc[$];
    logic [7:0] rx2_q[$];
    logic       prev_nss2 = 1'b1;

    always @(negedge clk) begin
        if (nss2 === 1'b0 && prev_nss2 === 1'b1) nss2_fall_cyc.push_back(cyc);
        if (nss2 === 1'b1 && prev_nss2 === 1'b0) nss2_rise_cyc.push_back(cyc);
        if (stsourcevalid2 === 1'b1 && stsourceready2 === 1'b1) rx2_q.push_back(stsourcedata2);
        prev_nss2 <= nss2;
    end

    task automatic clear_mon();
        rise_cyc.delete(); fall_cyc.delete(); nss_fall_cyc.delete(); nss_rise_cyc.delete();
        acc_cyc.delete(); drain_cyc.delete(); vrise_cyc.delete(); rise_bit.delete(); rx_q.delete();
        nss2_fall_cyc.delete(); nss2_rise_cyc.delete(); rx2_q.delete();
    endtask

    task automatic push(input logic [7:0] b, output logic ok);
        int n;
        n = 0;
        stsinkdata  = b;
        stsinkvalid = 1'b1;
        @(negedge clk);
        while (stsinkready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        stsinkvalid = 1'b0;
        ok = (n < 2000);
    endtask

    task automatic push2(input logic [7:0] b, output logic ok);
        int n;
        n = 0;
        stsinkdata2  = b;
        stsinkvalid2 = 1'b1;
        @(negedge clk);
        while (stsinkready2 !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        stsinkvalid2 = 1'b0;
        ok = (n < 2000);
    endtask

    task automatic wait_idle(output logic ok);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        ok = (n < 3000);
    endtask

    task automatic test_reset();
        reset = 1'b1; reset2 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (nss !== 1'b1) begin bad++; $display("FAIL reset_nss: got %b want 1", nss); end
        total++; if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        total++; if (mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (stsourcevalid !== 1'b0) begin bad++; $display("FAIL reset_srcvalid: got %b want 0", stsourcevalid); end
        total++; if (stsourcedata !== 8'h00) begin bad++; $display("FAIL reset_srcdata: got %h want 00", stsourcedata); end
        total++; if (stsinkready !== 1'b0) begin bad++; $display("FAIL reset_sinkready: got %b want 0", stsinkready); end
        @(posedge clk); #1;
        reset = 1'b0; reset2 = 1'b0;
        @(negedge clk);
        total++; if (stsinkready !== 1'b1) begin bad++; $display("FAIL idle_sinkready: got %b want 1", stsinkready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_byte();
        logic [7:0] tx, sl;
        logic ok1, ok2;
        int a, errs;
        for (int t = 0; t < 3; t++) begin
            tx = (t == 0) ? 8'hA5 : 8'($urandom);
            sl = (t == 0) ? 8'h3C : 8'($urandom);
            clear_mon();
            loopback = 1'b0; slave_byte = sl; stsourceready = 1'b1;
            push(tx, ok1);
            wait_idle(ok2);
            total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL single_timeout: got sink_ok=%b idle_ok=%b want 1 1", ok1, ok2); end
            a = (acc_cyc.size() > 0) ? acc_cyc[0] : -100;
            total++; if (rise_cyc.size() != 8 || fall_cyc.size() != 8) begin
                bad++; $display("FAIL single_pulses: got rises=%0d falls=%0d want 8 8", rise_cyc.size(), fall_cyc.size()); end
            errs = 0;
            for (int i = 0; i < 8; i++)
                if (i >= rise_bit.size() || rise_bit[i] !== 1'((tx >> (7 - i)) & 8'h01)) errs++;
            total++; if (errs != 0) begin bad++; $display("FAIL single_mosi_bits: got %0d wrong bits for tx %h want 0", errs, tx); end
            errs = 0;
            for (int i = 0; i < rise_cyc.size() && i < fall_cyc.size(); i++) begin
                if (fall_cyc[i] - rise_cyc[i] != DIV) errs++;
                if (i > 0 && rise_cyc[i] - fall_cyc[i-1] != DIV) errs++;
            end
            total++; if (errs != 0) begin bad++; $display("FAIL single_sclk_widths: got %0d bad phases want 0", errs); end
            total++; if (nss_fall_cyc.size() != 1 || nss_fall_cyc[0] != a + 1) begin
                bad++; $display("FAIL single_nss_fall: got %0d want %0d", (nss_fall_cyc.size() > 0) ? nss_fall_cyc[0] : -1, a + 1); end
            total++; if (rise_cyc.size() < 1 || rise_cyc[0] != a + 1 + CSS + DIV) begin
                bad++; $display("FAIL single_first_rise: got %0d want %0d", (rise_cyc.size() > 0) ? rise_cyc[0] : -1, a + 1 + CSS + DIV); end
            total++; if (vrise_cyc.size() != 1 || vrise_cyc[0] != a + 1 + CSS + 16 * DIV) begin
                bad++; $display("FAIL single_valid_rise: got %0d want %0d", (vrise_cyc.size() > 0) ? vrise_cyc[0] : -1, a + 1 + CSS + 16 * DIV); end
            total++; if (rx_q.size() != 1 || rx_q[0] !== sl) begin
                bad++; $display("FAIL single_rxdata: got %h (n=%0d) want %h", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, rx_q.size(), sl); end
            total++; if (nss_rise_cyc.size() != 1 || nss_fall_cyc.size() != 1 ||
                         nss_rise_cyc[0] - nss_fall_cyc[0] != CSS + 16 * DIV + 1 + CSS) begin
                bad++; $display("FAIL single_nss_low_len: got %0d want %0d",
                    (nss_rise_cyc.size() > 0 && nss_fall_cyc.size() > 0) ? nss_rise_cyc[0] - nss_fall_cyc[0] : -1,
                    CSS + 16 * DIV + 1 + CSS); end
        end
    endtask

    task automatic test_stream();
        logic [7:0] sent[$];
        logic ok, all_ok;
        int errs;
        for (int s = 0; s < 2; s++) begin
            sent.delete();
            if (s == 0) sent = '{8'h3C, 8'hC3, 8'hFF};
            else repeat (4) sent.push_back(8'($urandom));
            clear_mon();
            loopback = 1'b1; stsourceready = 1'b1;
            all_ok = 1'b1;
            foreach (sent[k]) begin push(sent[k], ok); all_ok &= ok; end
            wait_idle(ok); all_ok &= ok;
            total++; if (!all_ok) begin bad++; $display("FAIL stream_timeout: got 0 want 1"); end
            total++; if (nss_fall_cyc.size() != 1 || nss_rise_cyc.size() != 1) begin
                bad++; $display("FAIL stream_nss_edges: got falls=%0d rises=%0d want 1 1", nss_fall_cyc.size(), nss_rise_cyc.size()); end
            errs = (rx_q.size() == sent.size()) ? 0 : 1;
            foreach (sent[k]) if (k >= rx_q.size() || rx_q[k] !== sent[k]) errs++;
            total++; if (errs != 0) begin bad++; $display("FAIL stream_rxdata: got %0d mismatched bytes of %0d want 0", errs, sent.size()); end
            errs = (rise_cyc.size() == 8 * sent.size() && fall_cyc.size() == 8 * sent.size()) ? 0 : 1;
            for (int k = 1; k < sent.size(); k++)
                if (8 * k >= rise_cyc.size() || rise_cyc[8 * k] - fall_cyc[8 * k - 1] != 2 + DIV) errs++;
            total++; if (errs != 0) begin bad++; $display("FAIL stream_byte_gap: got %0d bad boundaries want 0", errs); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] b1, b2;
        logic ok1, ok2;
        int n, sclk_bad, nss_bad, rdy_bad, d;
        b1 = 8'($urandom); b2 = 8'($urandom);
        clear_mon();
        loopback = 1'b1; stsourceready = 1'b0;
        push(b1, ok1);
        stsinkdata = b2; stsinkvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (stsourcevalid !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        total++; if (!ok1 || n >= 1000) begin bad++; $display("FAIL bp_first_byte: got timeout want valid"); end
        sclk_bad = 0; nss_bad = 0; rdy_bad = 0;
        repeat (50) begin
            if (sclk !== 1'b0) sclk_bad++;
            if (nss !== 1'b0) nss_bad++;
            if (stsinkready !== 1'b0) rdy_bad++;
            @(negedge clk);
        end
        total++; if (sclk_bad != 0) begin bad++; $display("FAIL bp_sclk_stall: got %0d high cycles want 0", sclk_bad); end
        total++; if (nss_bad != 0) begin bad++; $display("FAIL bp_nss_stall: got %0d high cycles want 0", nss_bad); end
        total++; if (rdy_bad != 0) begin bad++; $display("FAIL bp_sinkready_stall: got %0d ready cycles want 0", rdy_bad); end
        @(posedge clk); #1;
        stsourceready = 1'b1;
        n = 0;
        @(negedge clk);
        while (acc_cyc.size() < 2 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        stsinkvalid = 1'b0;
        wait_idle(ok2);
        total++; if (n >= 100 || !ok2) begin bad++; $display("FAIL bp_second_byte: got timeout want accept"); end
        d = (drain_cyc.size() > 0) ? drain_cyc[0] : -100;
        total++; if (acc_cyc.size() != 2 || acc_cyc[1] != d + 1) begin
            bad++; $display("FAIL bp_accept_cycle: got %0d want %0d", (acc_cyc.size() > 1) ? acc_cyc[1] : -1, d + 1); end
        total++; if (rise_cyc.size() != 16 || rise_cyc[8] != d + 2 + DIV) begin
            bad++; $display("FAIL bp_restart: got %0d want %0d", (rise_cyc.size() > 8) ? rise_cyc[8] : -1, d + 2 + DIV); end
        total++; if (rx_q.size() != 2 || rx_q[0] !== b1 || rx_q[1] !== b2) begin
            bad++; $display("FAIL bp_rxdata: got n=%0d want %h %h", rx_q.size(), b1, b2); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] b, s2;
        logic ok1, ok2;
        int n, errs;
        b = 8'($urandom); s2 = 8'($urandom);
        clear_mon();
        loopback = 1'b0; slave_byte = 8'($urandom); stsourceready = 1'b1;
        push(b, ok1);
        n = 0;
        @(negedge clk);
        while (rise_cyc.size() < 3 && n < 1000) begin @(negedge clk); n++; end
        total++; if (!ok1 || n >= 1000) begin bad++; $display("FAIL abort_start: got timeout want 3 rises"); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (nss !== 1'b1) begin bad++; $display("FAIL abort_nss: got %b want 1", nss); end
        total++; if (sclk !== 1'b0) begin bad++; $display("FAIL abort_sclk: got %b want 0", sclk); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (150) @(negedge clk);
        @(posedge clk); #1;
        total++; if (vrise_cyc.size() != 0 || rx_q.size() != 0) begin
            bad++; $display("FAIL abort_no_valid: got %0d valid rises want 0", vrise_cyc.size()); end
        clear_mon();
        slave_byte = s2;
        push(8'h81, ok1);
        wait_idle(ok2);
        errs = (rise_bit.size() == 8) ? 0 : 1;
        for (int i = 0; i < 8 && i < rise_bit.size(); i++)
            if (rise_bit[i] !== 1'((8'h81 >> (7 - i)) & 8'h01)) errs++;
        total++; if (!ok1 || !ok2 || errs != 0) begin bad++; $display("FAIL abort_retry_mosi: got %0d errors want 0", errs); end
        total++; if (rx_q.size() != 1 || rx_q[0] !== s2) begin
            bad++; $display("FAIL abort_retry_rx: got %h (n=%0d) want %h", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, rx_q.size(), s2); end
    endtask

    task automatic test_loopback_div2();
        logic [7:0] pats[$];
        logic ok, all_ok;
        int n, errs;
        pats = '{8'h00, 8'hFF};
        pats.push_back(8'($urandom));
        clear_mon();
        stsourceready2 = 1'b1;
        all_ok = 1'b1;
        foreach (pats[k]) begin
            push2(pats[k], ok); all_ok &= ok;
            n = 0;
            @(negedge clk);
            while (nss2 !== 1'b1 && n < 500) begin @(negedge clk); n++; end
            if (n >= 500) all_ok = 1'b0;
            @(posedge clk); #1;
        end
        n = 0;
        @(negedge clk);
        while (busy2 !== 1'b0 && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) all_ok = 1'b0;
        @(posedge clk); #1;
        total++; if (!all_ok) begin bad++; $display("FAIL div2_timeout: got 0 want 1"); end
        errs = (rx2_q.size() == pats.size()) ? 0 : 1;
        foreach (pats[k]) if (k >= rx2_q.size() || rx2_q[k] !== pats[k]) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL div2_rxdata: got %0d mismatched bytes want 0", errs); end
        errs = (nss2_fall_cyc.size() == pats.size() && nss2_rise_cyc.size() == pats.size()) ? 0 : 1;
        for (int k = 1; k < nss2_fall_cyc.size() && k <= nss2_rise_cyc.size(); k++)
            if (nss2_fall_cyc[k] - nss2_rise_cyc[k-1] != CSS + 1) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL div2_nss_gap: got %0d bad gaps want 0 (gap %0d)", errs, CSS + 1); end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got hang want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        stsinkdata = 8'h00; stsinkvalid = 1'b0; stsourceready = 1'b0;
        stsinkdata2 = 8'h00; stsinkvalid2 = 1'b0; stsourceready2 = 1'b0;
        loopback = 1'b0; slave_byte = 8'h00;
        test_reset();
        test_single_byte();
        test_stream();
        test_backpressure();
        test_reset_abort();
        test_loopback_div2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
